seg7_to_bcd: RTL

Receiver-side decoder for the seven-segment bus driven by the floor display path: samples a SEG/COMC pattern, waits until it has been stable for a programmable number of clocks, then converts it back to a BCD digit with blank/invalid status. It sits at the monitor end of the display interface in the lift controller, alongside the BCD→segment driver. It lets the control logic and the test bench read back the digit actually being shown and count corrupted patterns.

---
 rtl/seg7_to_bcd.sv | 97 +++++++++
 1 files changed

// File: rtl/seg7_to_bcd.sv
// Seven-segment receiver: synchronizes SEG, waits for a stable pattern, then decodes it
// back to a BCD digit with blank/error status and a saturating error counter.
module seg7_to_bcd #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] SEG,
    input  logic       COMC,
    output logic [3:0] BCD,
    output logic       valid,
    output logic       blank,
    output logic       err,
    output logic       upd,
    output logic [7:0] err_cnt
);

    // One-hot so the status outputs come straight from state flops.
    typedef enum logic [2:0] {
        StBlank = 3'b010,
        StDigit = 3'b100,
        StError = 3'b001
    } state_e;

    localparam logic [3:0] CntMax    = 4'(STABLE_CYCLES);
    localparam logic [3:0] CommitCnt = 4'(STABLE_CYCLES - 1);

    logic [6:0] s1, s2, p, cand, cpat;
    logic [3:0] cnt;
    logic [3:0] dec_digit;
    logic       dec_hit;
    logic       commit, changed;
    state_e     state;

    assign p       = COMC ? ~s2 : s2;
    assign commit  = (p == cand) && (cnt == CommitCnt);
    assign changed = commit && (p != cpat);

    assign {valid, blank, err} = state;

    always_comb begin
        dec_hit   = 1'b1;
        dec_digit = 4'd0;
        unique case (p)
            7'b1111110: dec_digit = 4'd0;
            7'b0110000: dec_digit = 4'd1;
            7'b1101101: dec_digit = 4'd2;
            7'b1111001: dec_digit = 4'd3;
            7'b0110011: dec_digit = 4'd4;
            7'b1011011: dec_digit = 4'd5;
            7'b1011111: dec_digit = 4'd6;
            7'b1110000: dec_digit = 4'd7;
            7'b1111111: dec_digit = 4'd8;
            7'b1111011: dec_digit = 4'd9;
            default:    dec_hit   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            cand    <= '0;
            cnt     <= '0;
            cpat    <= '0;
            BCD     <= '0;
            upd     <= 1'b0;
            err_cnt <= '0;
            state   <= StBlank;
        end else begin
            s1  <= SEG;
            s2  <= s1;
            upd <= changed;

            if (p != cand) begin
                cand <= p;
                cnt  <= '0;
            end else if (cnt < CntMax) begin
                cnt <= cnt + 4'd1;
            end

            if (changed) begin
                cpat <= p;
                if (dec_hit) begin
                    BCD   <= dec_digit;
                    state <= StDigit;
                end else if (p == 7'd0) begin
                    state <= StBlank;
                end else begin
                    state <= StError;
                    if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
